// File: rtl/seq_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_tx_pkg
// Description : Shared types and helpers for the serial pattern transmitter.
//               Provides the FSM state type and the frame-length
//               normalisation used at accept time.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_tx_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

    // A requested length of 0, or one longer than the register, means
    // "send the full register".
    function automatic int norm_len(input int len, input int width);
        if ((len == 0) || (len > width)) begin
            return width;
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tx_shreg.sv
`default_nettype none
// ============================================================================
// Module      : seq_tx_shreg
// Description : Load/shift register feeding the serial line. The loaded word
//               is already aligned so that the first bit of the frame sits at
//               the tap; every shift moves the next bit onto the tap.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               load          - capture load_word (highest priority)
//               clear         - zero the register (line idles low)
//               shift         - advance one bit towards the tap
//               load_word     - pre-aligned frame word
//               tap           - current serial bit (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_tx_shreg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_word,
    output logic             tap
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_shifted;

    // Shift direction and tap position follow the bit order
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
            assign tap       = r_sr[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
            assign tap       = r_sr[0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= load_word;
        end else if (clear) begin
            r_sr <= '0;
        end else if (shift) begin
            r_sr <= w_shifted;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_tx
// Description : Serial pattern transmitter. Accepts a pattern word and length
//               over a valid/ready handshake, shifts it out one bit per clock
//               with a qualifying valid, then holds the line idle for GAP
//               cycles. With GAP=0 a new frame may be accepted in the last
//               bit cycle and follows with no bubble.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               load_valid/ready    - frame load handshake
//               load_data/load_len  - pattern bits and bit count
//               out_bit/out_valid   - serial line and its qualifier
//               busy                - frame in progress (SHIFT or GAP)
//               done                - one-cycle pulse after a frame's last bit
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LEN_W     = $clog2(WIDTH + 1),
    parameter int GAP       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    tx_state_t        r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_eff_len;
    logic [WIDTH-1:0] w_aligned;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;

    assign w_eff_len = LEN_W'(norm_len(int'(load_len), WIDTH));

    // MSB-first frames are pushed up so data[len-1] lands on the top tap;
    // bits above len-1 fall off the top and are never sent.
    generate
        if (MSB_FIRST != 0) begin : g_align_msb
            assign w_aligned = load_data << (LEN_W'(WIDTH) - w_eff_len);
        end else begin : g_align_lsb
            assign w_aligned = load_data;
        end
    endgenerate

    assign w_last   = (r_state == ST_SHIFT) && (r_bit_cnt == (r_len - LEN_W'(1)));
    // Back-to-back loading is only possible when there is no gap to insert
    assign w_ready  = (r_state == ST_IDLE) || ((GAP == 0) && w_last);
    assign w_accept = load_valid && w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_SHIFT;
                        r_len       <= w_eff_len;
                        r_bit_cnt   <= '0;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        r_done    <= 1'b1;
                        r_bit_cnt <= '0;
                        if (w_accept) begin
                            // Next frame starts immediately; line stays valid
                            r_len <= w_eff_len;
                        end else if (GAP > 0) begin
                            r_state     <= ST_GAP;
                            r_gap_cnt   <= GAP_W'(GAP);
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + LEN_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    seq_tx_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept),
        .clear     (w_last && !w_accept),
        .shift     ((r_state == ST_SHIFT) && !w_last),
        .load_word (w_aligned),
        .tap       (out_bit)
    );

    assign load_ready = w_ready;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_tx
// Description : Directed self-checking bench for seq_pattern_tx. Four
//               instances cover GAP=1/MSB-first (a), GAP=1/LSB-first (b),
//               GAP=0/MSB-first (c) and GAP=3/MSB-first (d).
//               Output vectors are packed as {out_valid,out_bit,busy,done,
//               load_ready}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic       a_lv, a_lr, a_ob, a_ov, a_busy, a_done;
    logic [7:0] a_ld;
    logic [3:0] a_ll;
    logic       b_lv, b_lr, b_ob, b_ov, b_busy, b_done;
    logic [7:0] b_ld;
    logic [3:0] b_ll;
    logic       c_lv, c_lr, c_ob, c_ov, c_busy, c_done;
    logic [7:0] c_ld;
    logic [3:0] c_ll;
    logic       d_lv, d_lr, d_ob, d_ov, d_busy, d_done;
    logic [7:0] d_ld;
    logic [3:0] d_ll;

    seq_pattern_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .load_valid(a_lv), .load_ready(a_lr),
        .load_data(a_ld), .load_len(a_ll), .out_bit(a_ob),
        .out_valid(a_ov), .busy(a_busy), .done(a_done));
    seq_pattern_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .load_valid(b_lv), .load_ready(b_lr),
        .load_data(b_ld), .load_len(b_ll), .out_bit(b_ob),
        .out_valid(b_ov), .busy(b_busy), .done(b_done));
    seq_pattern_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst), .load_valid(c_lv), .load_ready(c_lr),
        .load_data(c_ld), .load_len(c_ll), .out_bit(c_ob),
        .out_valid(c_ov), .busy(c_busy), .done(c_done));
    seq_pattern_tx #(.WIDTH(8), .GAP(3), .MSB_FIRST(1)) u_d (
        .clk(clk), .rst(rst), .load_valid(d_lv), .load_ready(d_lr),
        .load_data(d_ld), .load_len(d_ll), .out_bit(d_ob),
        .out_valid(d_ov), .busy(d_busy), .done(d_done));

    // Tasks start and end just after a falling edge.

    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b1;
        a_lv = 0; b_lv = 0; c_lv = 0; d_lv = 0;
        a_ld = 0; b_ld = 0; c_ld = 0; d_ld = 0;
        a_ll = 0; b_ll = 0; c_ll = 0; d_ll = 0;
        @(negedge clk);
        @(negedge clk);
        got = {a_ov, a_ob, a_busy, a_done, a_lr};
        n_cmp++; if (got !== 5'b00001) begin n_err++; $display("FAIL reset_a: got %b want 00001", got); end
        got = {b_ov, b_ob, b_busy, b_done, b_lr};
        n_cmp++; if (got !== 5'b00001) begin n_err++; $display("FAIL reset_b: got %b want 00001", got); end
        got = {c_ov, c_ob, c_busy, c_done, c_lr};
        n_cmp++; if (got !== 5'b00001) begin n_err++; $display("FAIL reset_c: got %b want 00001", got); end
        got = {d_ov, d_ob, d_busy, d_done, d_lr};
        n_cmp++; if (got !== 5'b00001) begin n_err++; $display("FAIL reset_d: got %b want 00001", got); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full frame on instance a: bits in cycles 1-8, done at 9, idle at 10
    task automatic test_msb_frame(input logic [7:0] data, input logic [3:0] len,
                                  input logic [7:0] bits, input string name);
        logic [4:0] got, exp;
        a_lv = 1; a_ld = data; a_ll = len;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 8)      exp = {1'b1, bits[8-k], 1'b1, 1'b0, 1'b0};
            else if (k == 9) exp = 5'b00110;
            else             exp = 5'b00001;
            got = {a_ov, a_ob, a_busy, a_done, a_lr};
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL %s k=%0d: got %b want %b", name, k, got, exp); end
            a_lv = 0;
        end
    endtask

    task automatic test_lsb_first();
        logic [4:0]  got, exp;
        logic [2:0]  short_bits = 3'b110;     // order sent: 0,1,1
        logic [7:0]  full_data  = 8'b1100_1010;
        // len=3: upper data bits are ones and must never appear
        b_lv = 1; b_ld = 8'b1111_1110; b_ll = 4'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 3)      exp = {1'b1, short_bits[k-1], 1'b1, 1'b0, 1'b0};
            else if (k == 4) exp = 5'b00110;
            else             exp = 5'b00001;
            got = {b_ov, b_ob, b_busy, b_done, b_lr};
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lsb_len3 k=%0d: got %b want %b", k, got, exp); end
            // Mid-frame input changes must have no effect
            b_lv = 0; b_ld = 8'h01; b_ll = 4'd1;
        end
        // len=0 sends all eight bits
        b_lv = 1; b_ld = full_data; b_ll = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 8)      exp = {1'b1, full_data[k-1], 1'b1, 1'b0, 1'b0};
            else if (k == 9) exp = 5'b00110;
            else             exp = 5'b00001;
            got = {b_ov, b_ob, b_busy, b_done, b_lr};
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lsb_len0 k=%0d: got %b want %b", k, got, exp); end
            b_lv = 0;
        end
    endtask

    task automatic test_one_bit();
        logic [4:0] got;
        logic [4:0] exp_tbl [3] = '{5'b11101, 5'b00011, 5'b00001};
        c_lv = 1; c_ld = 8'b1111_0001; c_ll = 4'd1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            got = {c_ov, c_ob, c_busy, c_done, c_lr};
            n_cmp++; if (got !== exp_tbl[k-1]) begin n_err++; $display("FAIL one_bit k=%0d: got %b want %b", k, got, exp_tbl[k-1]); end
            c_lv = 0;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  got, exp;
        logic [15:0] seq = 16'b1010_0101_0011_1100;
        c_lv = 1; c_ld = 8'hA5; c_ll = 4'd8;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k <= 16) exp = {1'b1, seq[16-k], 1'b1, (k == 9), (k == 8 || k == 16)};
            else         exp = 5'b00011;
            got = {c_ov, c_ob, c_busy, c_done, c_lr};
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL back_to_back k=%0d: got %b want %b", k, got, exp); end
            if (k == 1) c_ld = 8'h3C;   // frame B queued, valid held
            if (k == 9) c_lv = 0;
        end
    endtask

    task automatic test_gap();
        logic [4:0] got, exp;
        logic [3:0] a_bits = 4'b1011;
        logic [3:0] b_bits = 4'b0110;
        d_lv = 1; d_ld = 8'b1111_1011; d_ll = 4'd4;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 4)                 exp = {1'b1, a_bits[4-k], 1'b1, 1'b0, 1'b0};
            else if (k == 5)            exp = 5'b00110;
            else if (k <= 7)            exp = 5'b00100;
            else if (k == 8)            exp = 5'b00001;
            else if (k <= 12)           exp = {1'b1, b_bits[12-k], 1'b1, 1'b0, 1'b0};
            else if (k == 13)           exp = 5'b00110;
            else if (k <= 15)           exp = 5'b00100;
            else                        exp = 5'b00001;
            got = {d_ov, d_ob, d_busy, d_done, d_lr};
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL gap k=%0d: got %b want %b", k, got, exp); end
            if (k == 1) d_ld = 8'b1001_0110;
            if (k == 9) d_lv = 0;
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] got;
        a_lv = 1; a_ld = 8'hFF; a_ll = 4'd8;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            got = {a_ov, a_ob, a_busy, a_done, a_lr};
            n_cmp++; if (got !== 5'b11100) begin n_err++; $display("FAIL arst_pre k=%0d: got %b want 11100", k, got); end
            a_lv = 0;
        end
        // Assert between edges; outputs must drop before the next rising edge
        #2 rst = 1'b1;
        #1;
        got = {a_ov, a_ob, a_busy, a_done, a_lr};
        n_cmp++; if (got !== 5'b00001) begin n_err++; $display("FAIL arst_async: got %b want 00001", got); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            got = {a_ov, a_ob, a_busy, a_done, a_lr};
            n_cmp++; if (got !== 5'b00001) begin n_err++; $display("FAIL arst_nodone k=%0d: got %b want 00001", k, got); end
        end
    endtask

    // Overlapping "1001" detector on the qualified line; golden hits at 4 and 8
    task automatic test_detector();
        logic [3:0] hist = 4'b0000;
        logic       det, exp;
        a_lv = 1; a_ld = 8'b1001_1001; a_ll = 4'd8;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            a_lv = 0;
            det = 1'b0;
            if (a_ov) begin
                hist = {hist[2:0], a_ob};
                det  = (hist == 4'b1001);
            end
            exp = (k == 4) || (k == 8);
            n_cmp++; if (det !== exp) begin n_err++; $display("FAIL detector k=%0d: got %b want %b", k, det, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_msb_frame(8'b1001_0100, 4'd8,  8'b1001_0100, "msb_frame");
        test_msb_frame(8'b0000_0011, 4'd12, 8'b0000_0011, "len_clamp");
        test_lsb_first();
        test_one_bit();
        test_back_to_back();
        test_gap();
        test_async_reset();
        test_msb_frame(8'b0110_0011, 4'd8,  8'b0110_0011, "after_reset");
        test_detector();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
